uncache_arbiter: RTL and testbench
==================================

Name: uncache_arbiter

Overview:
- Sequences all uncached loads and stores onto the single uncached memory port.
- Arbitrates between the write buffer (uncached stores) and the read buffer (uncached loads). Stores take fixed priority to preserve MMIO ordering.
- Generates byte strobes and lane-aligned write data, and returns raw read words to the read buffer.
- Sits between wbuf/rbuf and the AXI-side bridge in the LSU.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, memory data width; only 32 is supported.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- w_req  in  1  wbuf has an uncached store
- w_addr  in  32  store byte address
- w_size  in  2  Size enum (s_nil/s_byte/s_half/s_word)
- w_data  in  32  store data, right-justified
- w_ready  out  1  store accepted (1-cycle pulse)
- w_done  out  1  store acknowledged by memory (1-cycle pulse)
- r_req  in  1  rbuf has an uncached load
- r_addr  in  32  load byte address
- r_size  in  2  Size enum
- r_ready  out  1  load accepted (1-cycle pulse)
- r_valid  out  1  load data valid (1-cycle pulse)
- r_data  out  32  raw aligned word
- flush  in  1  pipeline flush; kills loads
- m_valid  out  1  request to memory
- m_wen  out  1  1 = write
- m_addr  out  32  request address
- m_wdata  out  32  lane-aligned write data
- m_strobe  out  4  byte enables
- m_ready  in  1  memory accepted request
- m_rvalid  in  1  memory response (read data or write ack)
- m_rdata  in  32  read data
- m_rready  out  1  handler accepts response
- busy  out  1  state != IDLE

Behaviour:
- One clock; reset is asynchronous, active-low (resetn). On reset:
  - state = IDLE.
  - All outputs 0, except m_rready, which is also 0.
  - Any in-flight transaction is abandoned.
- FSM states: IDLE, W_REQ, W_RESP, R_REQ, R_RESP, R_DRAIN.
- IDLE:
  - w_req=1 → latch addr/size/data, pulse w_ready, go to W_REQ. A store wins over a simultaneous r_req.
  - Otherwise r_req=1 and flush=0 → latch, pulse r_ready, go to R_REQ.
  - Request with size s_nil → acknowledged (ready pulse, plus w_done or r_valid with r_data=0 on the next cycle). No memory access is issued.
- W_REQ / R_REQ: m_valid=1 with latched fields held stable until m_ready. On m_ready, go to W_RESP / R_RESP. m_valid drops the cycle after acceptance.
- W_RESP / R_RESP: m_rready=1.
  - W_RESP: on m_rvalid, pulse w_done, go to IDLE.
  - R_RESP: on m_rvalid, r_data = m_rdata, pulse r_valid, go to IDLE.
- Flush:
  - In R_REQ before m_ready: drop to IDLE; no memory access.
  - In R_REQ on the same cycle as m_ready, or in R_RESP: go to R_DRAIN. R_DRAIN waits for m_rvalid, suppresses r_valid, then returns to IDLE.
  - Flush never affects stores (they are committed).
  - Flush in IDLE blocks load acceptance that cycle.
- Strobe:
  - s_byte: 4'b0001 << addr[1:0].
  - s_half: addr[1] ? 4'b1100 : 4'b0011; addr[0] is ignored (alignment is checked upstream).
  - s_word: 4'b1111.
- Write data is shifted left by 8*addr[1:0]. m_addr is passed through unchanged.
- Loads use the same strobe for information only. r_data is the unshifted word; rbuf performs extract and sign-extend.
- Latency:
  - Accept to m_valid: 1 cycle.
  - Memory response to r_valid / w_done: same-cycle registered, i.e. visible the cycle after m_rvalid.
- Back-to-back: a new request may be accepted in the cycle the FSM re-enters IDLE. Throughput is at most one transaction per 3 cycles.
- At most one outstanding transaction; no pipelining.

Decomposition:
- Size enum stays in the shared LSU defines package. Add to it:
  - the FSM state enum (uarb_state_t);
  - function size2strobe(Size, logic[1:0]) → logic[3:0].
- No sub-module: strobe/shift logic is a package function; the FSM is inline.

Test Plan:
- Single word store, addr 0x1FD0_0004, data 0xDEADBEEF, m_ready delayed 2 cycles → m_valid held 3 cycles, m_wen=1, strobe 4'b1111, w_done one cycle after m_rvalid.
- Byte store, addr 0x...03, data 0x000000AB → m_strobe 4'b1000, m_wdata 0xAB000000.
- w_req and r_req asserted in the same cycle → store completes (w_done) before the load's m_valid rises; r_ready pulses only after returning to IDLE.
- Half load, addr 0x...02, m_rdata 0x1234_5678 → strobe 4'b1100, r_valid pulse with r_data 0x12345678.
- Flush during R_RESP, then m_rvalid 4 cycles later → no r_valid. busy stays 1 until m_rvalid, then 0. The next r_req is accepted afterwards.
- resetn dropped during W_REQ → outputs 0 immediately (asynchronously). After release, state = IDLE and a fresh store works.

Source files
------------

// File: rtl/uncache_arbiter_pkg.sv
// Shared LSU defines for the uncached path: access size, arbiter
// state encoding and byte-lane helpers.
package uncache_arbiter_pkg;

    typedef enum logic [1:0] {
        s_nil  = 2'd0,
        s_byte = 2'd1,
        s_half = 2'd2,
        s_word = 2'd3
    } size_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        W_REQ   = 3'd1,
        W_RESP  = 3'd2,
        R_REQ   = 3'd3,
        R_RESP  = 3'd4,
        R_DRAIN = 3'd5
    } uarb_state_t;

    // Byte enables for an access of the given size at byte offset off.
    // Halfword alignment is checked upstream, so off[0] is ignored.
    function automatic logic [3:0] size2strobe(input size_t size,
                                               input logic [1:0] off);
        logic [3:0] strb;
        strb = 4'b0000;
        unique case (size)
            s_byte:  strb = 4'b0001 << off;
            s_half:  strb = off[1] ? 4'b1100 : 4'b0011;
            s_word:  strb = 4'b1111;
            default: strb = 4'b0000;
        endcase
        return strb;
    endfunction

    // Move right-justified store data onto its byte lanes.
    function automatic logic [31:0] lane_align(input logic [31:0] data,
                                               input logic [1:0]  off);
        return data << {off, 3'b000};
    endfunction

endpackage

// File: rtl/uncache_arbiter.sv
// Uncached load/store sequencer: one transaction at a time onto the
// uncached memory port, stores ahead of loads to keep MMIO order.
module uncache_arbiter
    import uncache_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              w_req,
    input  logic [ADDR_W-1:0] w_addr,
    input  size_t             w_size,
    input  logic [DATA_W-1:0] w_data,
    output logic              w_ready,
    output logic              w_done,
    input  logic              r_req,
    input  logic [ADDR_W-1:0] r_addr,
    input  size_t             r_size,
    output logic              r_ready,
    output logic              r_valid,
    output logic [DATA_W-1:0] r_data,
    input  logic              flush,
    output logic              m_valid,
    output logic              m_wen,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic [3:0]        m_strobe,
    input  logic              m_ready,
    input  logic              m_rvalid,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              m_rready,
    output logic              busy
);

    uarb_state_t       state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        strobe_q;
    logic              w_done_d, r_valid_d;
    logic [DATA_W-1:0] r_data_d;
    logic              lat_w, lat_r;

    // Next-state, accept handshakes and response capture.
    always_comb begin
        state_d   = state_q;
        w_ready   = 1'b0;
        r_ready   = 1'b0;
        w_done_d  = 1'b0;
        r_valid_d = 1'b0;
        r_data_d  = r_data;
        lat_w     = 1'b0;
        lat_r     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (w_req) begin
                    // resetn gate keeps the accept pulse low while in reset
                    w_ready = resetn;
                    lat_w   = 1'b1;
                    if (w_size == s_nil) w_done_d = 1'b1;
                    else                 state_d  = W_REQ;
                end else if (r_req && !flush) begin
                    r_ready = resetn;
                    lat_r   = 1'b1;
                    if (r_size == s_nil) begin
                        r_valid_d = 1'b1;
                        r_data_d  = '0;
                    end else begin
                        state_d = R_REQ;
                    end
                end
            end
            W_REQ: begin
                if (m_ready) state_d = W_RESP;
            end
            W_RESP: begin
                if (m_rvalid) begin
                    w_done_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            R_REQ: begin
                if (flush) state_d = m_ready ? R_DRAIN : IDLE;
                else if (m_ready) state_d = R_RESP;
            end
            R_RESP: begin
                if (m_rvalid) begin
                    state_d = IDLE;
                    if (!flush) begin
                        r_valid_d = 1'b1;
                        r_data_d  = m_rdata;
                    end
                end else if (flush) begin
                    state_d = R_DRAIN;
                end
            end
            R_DRAIN: begin
                if (m_rvalid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register and registered completion outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            w_done  <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            state_q <= state_d;
            w_done  <= w_done_d;
            r_valid <= r_valid_d;
            r_data  <= r_data_d;
        end
    end

    // Capture the accepted request, pre-formatted for the memory port.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            strobe_q <= '0;
        end else if (lat_w) begin
            addr_q   <= w_addr;
            wdata_q  <= lane_align(w_data, w_addr[1:0]);
            strobe_q <= size2strobe(w_size, w_addr[1:0]);
        end else if (lat_r) begin
            addr_q   <= r_addr;
            wdata_q  <= '0;
            strobe_q <= size2strobe(r_size, r_addr[1:0]);
        end
    end

    assign m_valid  = (state_q == W_REQ) || (state_q == R_REQ);
    assign m_wen    = (state_q == W_REQ);
    assign m_rready = (state_q == W_RESP) || (state_q == R_RESP) ||
                      (state_q == R_DRAIN);
    assign busy     = (state_q != IDLE);
    assign m_addr   = addr_q;
    assign m_wdata  = wdata_q;
    assign m_strobe = strobe_q;

endmodule

// File: tb/tb_uncache_arbiter.sv
// Directed bench for uncache_arbiter: store/load paths, arbitration,
// flush handling, size-nil requests and asynchronous reset.
module tb_uncache_arbiter;
    import uncache_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        w_req;
    logic [31:0] w_addr;
    size_t       w_size;
    logic [31:0] w_data;
    logic        w_ready, w_done;
    logic        r_req;
    logic [31:0] r_addr;
    size_t       r_size;
    logic        r_ready, r_valid;
    logic [31:0] r_data;
    logic        flush;
    logic        m_valid, m_wen;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_strobe;
    logic        m_ready, m_rvalid;
    logic [31:0] m_rdata;
    logic        m_rready, busy;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    uncache_arbiter dut (
        .clk(clk), .resetn(resetn),
        .w_req(w_req), .w_addr(w_addr), .w_size(w_size), .w_data(w_data),
        .w_ready(w_ready), .w_done(w_done),
        .r_req(r_req), .r_addr(r_addr), .r_size(r_size),
        .r_ready(r_ready), .r_valid(r_valid), .r_data(r_data),
        .flush(flush),
        .m_valid(m_valid), .m_wen(m_wen), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_strobe(m_strobe), .m_ready(m_ready),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rready(m_rready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        resetn = 1'b0;
        w_req = 0; w_addr = 0; w_size = s_nil; w_data = 0;
        r_req = 0; r_addr = 0; r_size = s_nil;
        flush = 0; m_ready = 0; m_rvalid = 0; m_rdata = 0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_mvalid", m_valid, 0);
        chk("rst_mrready", m_rready, 0);
        chk("rst_wdone", w_done, 0);
        chk("rst_rvalid", r_valid, 0);
        chk("rst_strobe", m_strobe, 0);
        tick;
        resetn = 1'b1;
        #1;

        // word store, m_ready delayed two cycles
        w_req = 1; w_addr = 32'h1FD0_0004; w_size = s_word;
        w_data = 32'hDEAD_BEEF;
        #1;
        chk("w1_ready", w_ready, 1);
        chk("w1_mvalid_pre", m_valid, 0);
        tick; w_req = 0; #1;
        chk("w1_mvalid_c1", m_valid, 1);
        chk("w1_wen", m_wen, 1);
        chk("w1_strobe", m_strobe, 4'hF);
        chk("w1_addr", m_addr, 32'h1FD0_0004);
        chk("w1_wdata", m_wdata, 32'hDEAD_BEEF);
        chk("w1_ready_drop", w_ready, 0);
        tick; #1;
        chk("w1_mvalid_c2", m_valid, 1);
        tick; m_ready = 1; #1;
        chk("w1_mvalid_c3", m_valid, 1);
        tick; m_ready = 0; #1;
        chk("w1_mvalid_drop", m_valid, 0);
        chk("w1_mrready", m_rready, 1);
        m_rvalid = 1; #1;
        chk("w1_done_early", w_done, 0);
        tick; m_rvalid = 0; #1;
        chk("w1_done", w_done, 1);
        chk("w1_idle", busy, 0);
        tick; #1;
        chk("w1_done_pulse", w_done, 0);

        // byte store at offset 3
        w_req = 1; w_addr = 32'h1FD0_0003; w_size = s_byte;
        w_data = 32'h0000_00AB;
        #1;
        chk("wb_ready", w_ready, 1);
        tick; w_req = 0; m_ready = 1; #1;
        chk("wb_strobe", m_strobe, 4'b1000);
        chk("wb_wdata", m_wdata, 32'hAB00_0000);
        tick; m_ready = 0; m_rvalid = 1; #1;
        tick; m_rvalid = 0; #1;
        chk("wb_done", w_done, 1);

        // simultaneous store and load: store goes first
        w_req = 1; w_addr = 32'h1FD0_0010; w_size = s_word;
        w_data = 32'h1122_3344;
        r_req = 1; r_addr = 32'h1FD0_0020; r_size = s_word;
        #1;
        chk("arb_wready", w_ready, 1);
        chk("arb_rready_c0", r_ready, 0);
        tick; w_req = 0; m_ready = 1; #1;
        chk("arb_wen", m_wen, 1);
        chk("arb_rready_c1", r_ready, 0);
        tick; m_ready = 0; m_rvalid = 1; #1;
        chk("arb_mvalid_resp", m_valid, 0);
        chk("arb_rready_c2", r_ready, 0);
        tick; m_rvalid = 0; #1;
        chk("arb_wdone", w_done, 1);
        chk("arb_mvalid_idle", m_valid, 0);
        chk("arb_rready_idle", r_ready, 1);
        tick; r_req = 0; #1;
        chk("arb_rd_mvalid", m_valid, 1);
        chk("arb_rd_wen", m_wen, 0);
        chk("arb_rd_addr", m_addr, 32'h1FD0_0020);
        m_ready = 1;
        tick; m_ready = 0; m_rvalid = 1; m_rdata = 32'hCAFE_F00D; #1;
        tick; m_rvalid = 0; #1;
        chk("arb_rvalid", r_valid, 1);
        chk("arb_rdata", r_data, 32'hCAFE_F00D);

        // half load at offset 2, raw word returned
        r_req = 1; r_addr = 32'h1FD0_0042; r_size = s_half; #1;
        chk("rh_ready", r_ready, 1);
        tick; r_req = 0; m_ready = 1; #1;
        chk("rh_strobe", m_strobe, 4'b1100);
        tick; m_ready = 0; m_rvalid = 1; m_rdata = 32'h1234_5678; #1;
        chk("rh_rvalid_early", r_valid, 0);
        tick; m_rvalid = 0; #1;
        chk("rh_rvalid", r_valid, 1);
        chk("rh_rdata", r_data, 32'h1234_5678);
        tick; #1;
        chk("rh_rvalid_pulse", r_valid, 0);

        // flush in R_RESP, response four cycles later is drained
        r_req = 1; r_addr = 32'h1FD0_0050; r_size = s_word;
        tick; r_req = 0; m_ready = 1;
        tick; m_ready = 0; flush = 1; #1;
        chk("fl_busy_f0", busy, 1);
        chk("fl_mrready", m_rready, 1);
        tick; flush = 0; #1;
        chk("fl_busy_f1", busy, 1);
        chk("fl_rvalid_f1", r_valid, 0);
        tick; #1;
        chk("fl_busy_f2", busy, 1);
        tick; #1;
        chk("fl_busy_f3", busy, 1);
        tick; m_rvalid = 1; m_rdata = 32'h5555_AAAA; #1;
        chk("fl_busy_f4", busy, 1);
        tick; m_rvalid = 0; #1;
        chk("fl_rvalid_sup", r_valid, 0);
        chk("fl_idle", busy, 0);
        r_req = 1; #1;
        chk("fl_next_ready", r_ready, 1);
        tick; r_req = 0; #1;
        chk("fl_next_mvalid", m_valid, 1);
        m_ready = 1;
        tick; m_ready = 0; m_rvalid = 1; m_rdata = 32'h0BAD_F00D;
        tick; m_rvalid = 0; #1;
        chk("fl_next_rdata", r_data, 32'h0BAD_F00D);
        chk("fl_next_rvalid", r_valid, 1);

        // flush in R_REQ before acceptance: back to IDLE, no access
        r_req = 1; r_addr = 32'h1FD0_0060;
        tick; r_req = 0; flush = 1; #1;
        chk("flq_mvalid", m_valid, 1);
        tick; flush = 0; #1;
        chk("flq_busy", busy, 0);
        chk("flq_mvalid_drop", m_valid, 0);

        // flush in IDLE blocks load acceptance
        r_req = 1; flush = 1; #1;
        chk("fli_blocked", r_ready, 0);
        tick; r_req = 0; flush = 0; #1;
        chk("fli_busy", busy, 0);

        // size nil store and load: acknowledged without memory access
        w_req = 1; w_size = s_nil; #1;
        chk("nw_ready", w_ready, 1);
        tick; w_req = 0; #1;
        chk("nw_done", w_done, 1);
        chk("nw_mvalid", m_valid, 0);
        chk("nw_busy", busy, 0);
        r_req = 1; r_size = s_nil; #1;
        chk("nr_ready", r_ready, 1);
        tick; r_req = 0; #1;
        chk("nr_rvalid", r_valid, 1);
        chk("nr_rdata", r_data, 0);
        chk("nr_mvalid", m_valid, 0);

        // asynchronous reset while in W_REQ
        w_req = 1; w_addr = 32'h1FD0_0070; w_size = s_word;
        w_data = 32'h7777_7777;
        tick; w_req = 0; #1;
        chk("ar_mvalid_pre", m_valid, 1);
        #2; resetn = 0; #1;
        chk("ar_mvalid", m_valid, 0);
        chk("ar_busy", busy, 0);
        chk("ar_strobe", m_strobe, 0);
        chk("ar_addr", m_addr, 0);
        tick; resetn = 1; #1;
        chk("ar_idle", busy, 0);

        // fresh half store at offset 2 after reset
        w_req = 1; w_addr = 32'h1FD0_0062; w_size = s_half;
        w_data = 32'h0000_BEEF; #1;
        chk("ar_wready", w_ready, 1);
        tick; w_req = 0; m_ready = 1; #1;
        chk("ar_wstrobe", m_strobe, 4'b1100);
        chk("ar_wdata", m_wdata, 32'hBEEF_0000);
        tick; m_ready = 0; m_rvalid = 1;
        tick; m_rvalid = 0; #1;
        chk("ar_wdone", w_done, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
